// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : 2R/1W register file with busy scoreboard, bypass and sequenced clear
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [WIDTH-1:0]  reg_write_data,
    input  logic              reg_rsv_en,
    input  logic [ADDR_W-1:0] reg_rsv_dest,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    output logic [WIDTH-1:0]  reg_read_data_1,
    output logic              reg_read_busy_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    output logic [WIDTH-1:0]  reg_read_data_2,
    output logic              reg_read_busy_2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0]      c_st_idle  = 1'b0;
    localparam logic [0:0]      c_st_clear = 1'b1;
    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W + 1)'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [ADDR_W:0]  r_idx;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_idle;
    logic w_last;
    logic w_wr_ok;
    logic w_rsv_ok;

    assign w_idle   = (r_state == c_st_idle);
    assign w_last   = (r_idx == c_last_idx);
    assign w_wr_ok  = w_idle && reg_write_en && !((ZERO_R0 != 0) && (reg_write_dest == '0));
    assign w_rsv_ok = w_idle && reg_rsv_en && !((ZERO_R0 != 0) && (reg_rsv_dest == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (clr_req) w_state_next = c_st_clear;
            c_st_clear: if (w_last)  w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        clr_busy = (r_state == c_st_clear);
        clr_done = (r_state == c_st_clear) && w_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (r_state == c_st_clear) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end else begin
            r_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == c_st_clear) begin
            r_mem[r_idx[ADDR_W-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem[reg_write_dest] <= reg_write_data;
        end
    end

    // Reserve is applied after write so a new producer wins on the same address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else if (r_state == c_st_clear) begin
            r_busy[r_idx[ADDR_W-1:0]] <= 1'b0;
        end else begin
            if (w_wr_ok)  r_busy[reg_write_dest] <= 1'b0;
            if (w_rsv_ok) r_busy[reg_rsv_dest]   <= 1'b1;
        end
    end

    function automatic logic [WIDTH-1:0] rd_data(input logic [ADDR_W-1:0] addr);
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && w_wr_ok && (reg_write_dest == addr)) begin
            return reg_write_data;
        end else begin
            return r_mem[addr];
        end
    endfunction

    function automatic logic rd_busy(input logic [ADDR_W-1:0] addr);
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            return 1'b0;
        end else if ((BYPASS != 0) && w_wr_ok && (reg_write_dest == addr)) begin
            return w_rsv_ok && (reg_rsv_dest == addr);
        end else begin
            return r_busy[addr];
        end
    endfunction

    assign reg_read_data_1 = rd_data(reg_read_addr_1);
    assign reg_read_busy_1 = rd_busy(reg_read_addr_1);
    assign reg_read_data_2 = rd_data(reg_read_addr_2);
    assign reg_read_busy_2 = rd_busy(reg_read_addr_2);

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : directed + random check of regfile_scoreboard (plain and zero-R0)
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  wd;
    logic [15:0] wdata;
    logic        rsv;
    logic [2:0]  rd;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic        clr_req;

    logic [15:0] d1_a, d2_a, d1_z, d2_z;
    logic        b1_a, b2_a, b1_z, b2_z;
    logic        cb_a, cd_a, cb_z, cd_z;

    int n_total = 0;
    int n_bad   = 0;
    int cnt_busy;
    int cnt_done;

    // Reference state: [0] plain instance, [1] zero-R0 instance.
    logic [15:0] m_mem  [2][DEPTH];
    logic        m_busy [2][DEPTH];
    logic        m_clr;
    int          m_idx;

    always #5 clk = ~clk;

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .reg_write_en(we), .reg_write_dest(wd), .reg_write_data(wdata),
        .reg_rsv_en(rsv), .reg_rsv_dest(rd),
        .reg_read_addr_1(a1), .reg_read_data_1(d1_a), .reg_read_busy_1(b1_a),
        .reg_read_addr_2(a2), .reg_read_data_2(d2_a), .reg_read_busy_2(b2_a),
        .clr_req(clr_req), .clr_busy(cb_a), .clr_done(cd_a)
    );

    regfile_scoreboard #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) u_dut_z (
        .clk(clk), .rst(rst),
        .reg_write_en(we), .reg_write_dest(wd), .reg_write_data(wdata),
        .reg_rsv_en(rsv), .reg_rsv_dest(rd),
        .reg_read_addr_1(a1), .reg_read_data_1(d1_z), .reg_read_busy_1(b1_z),
        .reg_read_addr_2(a2), .reg_read_data_2(d2_z), .reg_read_busy_2(b2_z),
        .clr_req(clr_req), .clr_busy(cb_z), .clr_done(cd_z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
        m_clr = 1'b0;
        m_idx = 0;
    endtask

    function automatic logic is_r0(input int k, input logic [2:0] a);
        return (k == 1) && (a == 3'd0);
    endfunction

    task automatic exp_read(input int k, input logic [2:0] a,
                            output logic [15:0] d, output logic b);
        if (is_r0(k, a)) begin
            d = '0; b = 1'b0;
        end else if (!m_clr && we && wd == a) begin
            d = wdata; b = rsv && (rd == a);
        end else begin
            d = m_mem[k][a]; b = m_busy[k][a];
        end
    endtask

    task automatic model_step();
        if (!m_clr) begin
            for (int k = 0; k < 2; k++) begin
                if (we && !is_r0(k, wd)) begin
                    m_mem[k][wd]  = wdata;
                    m_busy[k][wd] = 1'b0;
                end
                if (rsv && !is_r0(k, rd)) m_busy[k][rd] = 1'b1;
            end
            if (clr_req) begin
                m_clr = 1'b1;
                m_idx = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_mem[k][m_idx]  = '0;
                m_busy[k][m_idx] = 1'b0;
            end
            if (m_idx == DEPTH - 1) m_clr = 1'b0;
            else m_idx++;
        end
    endtask

    task automatic check_all();
        logic [15:0] ed;
        logic        eb;
        logic        e_done;
        e_done = m_clr && (m_idx == DEPTH - 1);
        exp_read(0, a1, ed, eb); chk("data1", {16'd0, d1_a}, {16'd0, ed}); chk("busy1", 32'(b1_a), 32'(eb));
        exp_read(0, a2, ed, eb); chk("data2", {16'd0, d2_a}, {16'd0, ed}); chk("busy2", 32'(b2_a), 32'(eb));
        exp_read(1, a1, ed, eb); chk("z_data1", {16'd0, d1_z}, {16'd0, ed}); chk("z_busy1", 32'(b1_z), 32'(eb));
        exp_read(1, a2, ed, eb); chk("z_data2", {16'd0, d2_z}, {16'd0, ed}); chk("z_busy2", 32'(b2_z), 32'(eb));
        chk("clr_busy", 32'(cb_a), 32'(m_clr));
        chk("clr_done", 32'(cd_a), 32'(e_done));
        chk("z_clr_busy", 32'(cb_z), 32'(m_clr));
        chk("z_clr_done", 32'(cd_z), 32'(e_done));
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 time unit later.
    task automatic tick();
        #1;
        check_all();
        cnt_busy += int'(cb_a);
        cnt_done += int'(cd_a);
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 0; wd = 0; wdata = 0; rsv = 0; rd = 0; clr_req = 0;
    endtask

    initial begin
        rst = 0; a1 = 0; a2 = 0;
        idle_inputs();
        model_reset();
        cnt_busy = 0; cnt_done = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            tick();
        end
        rst = 1;

        // Write with same-cycle bypass, then stored read.
        we = 1; wd = 3; wdata = 16'hABCD; a1 = 3;
        #1 chk("t1_bypass", {16'd0, d1_a}, 32'hABCD);
        tick();
        we = 0;
        #1 chk("t1_stored", {16'd0, d1_a}, 32'hABCD);
        chk("t1_busy", 32'(b1_a), 32'd0);
        tick();

        // Reserve then resolving write.
        rsv = 1; rd = 5; tick();
        rsv = 0; a2 = 5;
        #1 chk("t2_busy", 32'(b2_a), 32'd1);
        tick();
        we = 1; wd = 5; wdata = 16'h1234;
        #1 chk("t2_fwd", {16'd0, d2_a}, 32'h1234);
        chk("t2_fwd_busy", 32'(b2_a), 32'd0);
        tick();
        we = 0;
        #1 chk("t2_after_busy", 32'(b2_a), 32'd0);
        tick();

        // Reserve and write the same register.
        we = 1; wd = 2; wdata = 16'h00FF; rsv = 1; rd = 2; a1 = 2;
        tick();
        idle_inputs();
        #1 chk("t3_data", {16'd0, d1_a}, 32'h00FF);
        chk("t3_busy", 32'(b1_a), 32'd1);
        tick();

        // Zero-R0 instance ignores writes and reserves to R0.
        we = 1; wd = 0; wdata = 16'hFFFF; rsv = 1; rd = 0; a1 = 0; a2 = 0;
        #1 chk("t4_fwd_z", {16'd0, d1_z}, 32'd0);
        tick();
        idle_inputs();
        #1 chk("t4_d1_z", {16'd0, d1_z}, 32'd0);
        chk("t4_b1_z", 32'(b1_z), 32'd0);
        chk("t4_d2_z", {16'd0, d2_z}, 32'd0);
        chk("t4_b2_z", 32'(b2_z), 32'd0);
        chk("t4_d1_plain", {16'd0, d1_a}, 32'hFFFF);
        tick();

        // Full sequenced clear with a dropped mid-clear write.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1; wd = 3'(i); wdata = 16'(16'h1001 + i); a1 = 3'(i);
            tick();
        end
        idle_inputs();
        cnt_busy = 0; cnt_done = 0;
        clr_req = 1; tick();
        clr_req = 0;
        for (int c = 0; c < 10; c++) begin
            we = (c == 3); wd = 4; wdata = 16'hBEEF; a1 = 4;
            tick();
        end
        idle_inputs();
        chk("t5_busy_cycles", 32'(cnt_busy), 32'd8);
        chk("t5_done_pulses", 32'(cnt_done), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            a1 = 3'(i); a2 = 3'(i);
            #1 chk("t5_cleared", {16'd0, d1_a}, 32'd0);
            tick();
        end

        // Reset in the middle of a clear.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; wd = 3'(i); wdata = 16'(16'h7700 + i); rsv = 1; rd = 3'(i);
            tick();
        end
        idle_inputs();
        clr_req = 1; tick();
        clr_req = 0;
        repeat (3) tick();
        cnt_done = 0;
        rst = 0;
        #1 chk("t6_clr_busy", 32'(cb_a), 32'd0);
        chk("t6_clr_done", 32'(cd_a), 32'd0);
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            a1 = 3'(i); a2 = 3'(i);
            tick();
        end
        chk("t6_no_done", 32'(cnt_done), 32'd0);
        rst = 1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            wd      = 3'($urandom);
            wdata   = 16'($urandom);
            rsv     = ($urandom_range(0, 2) == 0);
            rd      = 3'($urandom);
            a1      = ($urandom_range(0, 3) == 0) ? wd : 3'($urandom);
            a2      = ($urandom_range(0, 3) == 0) ? rd : 3'($urandom);
            clr_req = ($urandom_range(0, 40) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
